// File: rtl/ds18b20_scheduler.sv
// ds18b20_scheduler: merges periodic polls and on-demand requests into DS18B20 conversions.
// It also tracks the sensor timeout and keeps the last good temperature.
module ds18b20_scheduler #(
  parameter int POLL_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_poll_en,
  input  logic [1:0]  i_req,
  output logic [1:0]  o_ack,
  output logic        o_sensor_start,
  input  logic        i_sensor_done,
  input  logic [16:0] i_sensor_temp,
  output logic [16:0] o_temp,
  output logic        o_temp_valid,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_fail_cnt
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2, UPDATE = 2'd3;
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    state_q, state_d, pend_q, pend_d, served_q, served_d;
  logic          poll_pend_q, poll_pend_d, temp_valid_q, temp_valid_d, timeout_q, timeout_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [16:0]   temp_q, temp_d;
  logic [7:0]    fail_q, fail_d;
  logic          wrap, expired;
  assign wrap    = pcnt_q == PW'(POLL_CYCLES - 1);
  assign expired = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  // The temperature is captured directly on done so o_temp and o_ack appear together one cycle later
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q | i_req;
    served_d     = served_q;
    temp_d       = temp_q;
    temp_valid_d = temp_valid_q;
    timeout_d    = timeout_q;
    fail_d       = fail_q;
    pcnt_d       = (!i_poll_en || wrap) ? '0 : pcnt_q + PW'(1);
    poll_pend_d  = i_poll_en & (wrap | (poll_pend_q & (state_q != START)));
    tcnt_d       = (state_q == WAIT_DONE) ? tcnt_q + TW'(1) : '0;
    case (state_q)
      IDLE: state_d = (|pend_q || poll_pend_q) ? START : IDLE;
      START: begin
        served_d = pend_q;
        pend_d   = i_req;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_sensor_done) begin
          temp_d       = i_sensor_temp;
          temp_valid_d = 1'b1;
          timeout_d    = 1'b0;
          state_d      = UPDATE;
        end else if (expired) begin
          timeout_d = 1'b1;
          fail_d    = fail_q + {7'd0, fail_q != 8'hff};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      served_q     <= '0;
      poll_pend_q  <= 1'b0;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      fail_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      served_q     <= served_d;
      poll_pend_q  <= poll_pend_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      timeout_q    <= timeout_d;
      fail_q       <= fail_d;
    end
  end
  assign o_sensor_start = state_q == START;
  assign o_ack          = (state_q == UPDATE) ? served_q : 2'b00;
  assign o_busy         = state_q != IDLE;
  assign o_temp         = temp_q;
  assign o_temp_valid   = temp_valid_q;
  assign o_timeout      = timeout_q;
  assign o_fail_cnt     = fail_q;
endmodule

// File: tb/tb_ds18b20_scheduler.sv
// tb_ds18b20_scheduler: scoreboard bench with a transaction-level reference model.
// A sensor responder pushes expected outcomes; a monitor pops and checks them on their due cycle.
module tb_ds18b20_scheduler;
  localparam int P = 100, T = 40;
  logic clk = 0, rst_n = 0, poll_en = 0, done = 0;
  logic [1:0] req = 0, ack;
  logic start, tvalid, busy, tout;
  logic [16:0] stemp = 0, temp;
  logic [7:0] fail;
  ds18b20_scheduler #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_poll_en(poll_en), .i_req(req), .o_ack(ack),
    .o_sensor_start(start), .i_sensor_done(done), .i_sensor_temp(stemp), .o_temp(temp),
    .o_temp_valid(tvalid), .o_busy(busy), .o_timeout(tout), .o_fail_cnt(fail)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  typedef struct {int due; logic ok; logic [1:0] ack; logic [16:0] temp;} ev_t;
  ev_t q[$];
  int tests = 0, errs = 0;
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction
  // Monitor: expected architectural state advances only when a scoreboard event falls due
  logic [16:0] m_temp = 0;
  logic m_valid = 0, m_to = 0;
  int m_fail = 0;
  always @(negedge clk) begin
    ev_t e;
    logic [1:0] ea;
    ea = 2'b00;
    if (!rst_n) begin
      m_temp = 0; m_valid = 0; m_to = 0; m_fail = 0;
      q.delete();
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.ok) begin
        m_temp = e.temp; m_valid = 1; m_to = 0; ea = e.ack;
      end else begin
        m_to = 1; m_fail += (m_fail < 255);
      end
    end
    chk("ack", ack, ea);
    chk("temp", temp, m_temp);
    chk("temp_valid", tvalid, m_valid);
    chk("timeout", tout, m_to);
    chk("fail_cnt", fail, m_fail);
  end
  // Driver/responder state: model pending set, scheduled done, and start deadline
  logic [1:0] pend = 0;
  logic [16:0] done_temp = 0, fix_temp = 0;
  int done_cyc = -1, start_by = -1, mode = 0, fix_dd = 20, n;
  bit spur = 0, prev_start = 0;
  task automatic cycle(input logic [1:0] rq);
    int dd;
    logic [1:0] served;
    @(negedge clk);
    req = 0; done = 0; stemp = 17'($urandom);
    chk("start_pulse", start & prev_start, 0);
    prev_start = start;
    if (start) begin
      served = pend; pend = 0; start_by = -1;
      dd = mode == 1 ? fix_dd : mode == 0 ? ($urandom_range(0, 3) == 0 ? T : int'($urandom_range(1, T + 8))) : T + 1;
      done_temp = mode == 1 ? fix_temp : 17'($urandom);
      if (mode != 3) begin
        if (dd <= T) begin
          q.push_back('{cyc + 1 + dd, 1'b1, served, done_temp});
          done_cyc = cyc + dd;
        end else q.push_back('{cyc + 1 + T, 1'b0, 2'b00, 17'd0});
      end
    end
    if (start_by == cyc) begin
      chk("start_latency", start, 1);
      start_by = -1;
    end
    if (cyc == done_cyc) begin
      done = 1; stemp = done_temp; done_cyc = -1;
    end else if (spur && !busy && $urandom_range(0, 5) == 0) done = 1;
    if (rst_n && !busy && pend != 0 && start_by < 0) start_by = cyc + 1;
    if (rq != 0) begin
      if (rst_n && !busy && pend == 0 && start_by < 0) start_by = cyc + 2;
      req = rq; pend |= rq;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) cycle(0);
    rst_n = 1;
    mode = 1; fix_dd = 20; fix_temp = 17'h00191;
    poll_en = 1; n = 0;
    while (!start && n < 300) begin
      cycle(0); n++;
    end
    chk("poll_first_start", n, 101);
    poll_en = 0;
    repeat (30) cycle(0);
    chk("poll_temp", temp, 17'h00191);
    fix_temp = 17'h1f2a5;
    cycle(2'b01); cycle(2'b10);
    repeat (30) cycle(0);
    fix_temp = 17'h00aa0;
    cycle(2'b01); repeat (5) cycle(0); cycle(2'b10);
    repeat (60) cycle(0);
    mode = 2;
    cycle(2'b01); repeat (50) cycle(0);
    chk("timeout_set", tout, 1);
    mode = 1; fix_dd = 7; fix_temp = 17'h00321;
    cycle(2'b10); repeat (20) cycle(0);
    chk("timeout_cleared", tout, 0);
    fix_dd = T; fix_temp = 17'h0beef;
    cycle(2'b01); repeat (50) cycle(0);
    chk("coincident_fail", fail, 1);
    mode = 0; spur = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 250) poll_en = ~poll_en;
      cycle($urandom_range(0, 9) == 0 ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    spur = 0; poll_en = 0; n = 0;
    while ((q.size() > 0 || busy || pend != 0) && n < 500) begin
      cycle(0); n++;
    end
    chk("drain_pend", pend, 0);
    chk("drain_queue", q.size(), 0);
    mode = 2;
    for (int i = 0; i < 258; i++) begin
      cycle(2'b01); repeat (45) cycle(0);
    end
    chk("fail_saturate", fail, 255);
    mode = 1; fix_dd = 5; fix_temp = 17'h12345;
    cycle(2'b10); repeat (10) cycle(0);
    chk("sat_success_clears", tout, 0);
    mode = 3;
    cycle(2'b01); repeat (8) cycle(0);
    chk("busy_before_reset", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_start", start, 0);
    chk("rst_temp", temp, 0);
    chk("rst_valid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tout, 0);
    chk("rst_fail", fail, 0);
    pend = 0; done_cyc = -1; start_by = -1;
    repeat (2) cycle(0);
    rst_n = 1;
    done_cyc = cyc + 1; done_temp = 17'h1abcd;
    repeat (10) cycle(0);
    chk("late_done_valid", tvalid, 0);
    chk("late_done_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
